// File: rtl/row_clear.sv
// Removes one completed row from a latched board copy, shifting rows above it down and zeroing row 0.
// Latency: update_valid strobes R+1 edges after the capture edge for row R (plus any paused cycles).
// Backpressure: pause freezes all state; busy holds the upstream scanner while a clear is in progress.
module row_clear #(
  parameter int BLOCK_WIDTH   = 10,
  parameter int BLOCK_HEIGHT  = 20,
  parameter int Y_POS_IN_BITS = 5,
  parameter int LINES_BITS    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                pause,
  input  logic [BLOCK_WIDTH*BLOCK_HEIGHT-1:0] placed_tetrominos,
  input  logic [Y_POS_IN_BITS-1:0]            row,
  input  logic                                enabled,
  output logic                                busy,
  output logic                                update_valid,
  output logic [BLOCK_WIDTH*BLOCK_HEIGHT-1:0] cleared_board,
  output logic [LINES_BITS-1:0]               lines_cleared
);

  localparam int BW = BLOCK_WIDTH * BLOCK_HEIGHT;

  typedef enum logic [1:0] {IDLE, SHIFT, CLEAR_TOP, DONE} state_t;

  state_t                   state, state_nxt;
  logic [Y_POS_IN_BITS-1:0] cur;
  logic [BW-1:0]            shifted;
  logic                     capture;

  assign capture = enabled && !pause && (int'(row) < BLOCK_HEIGHT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    update_valid = 1'b0;
    case (state)
      IDLE:      if (capture) state_nxt = (row != '0) ? SHIFT : CLEAR_TOP;
      SHIFT:     if (!pause && cur == Y_POS_IN_BITS'(1)) state_nxt = CLEAR_TOP;
      CLEAR_TOP: if (!pause) state_nxt = DONE;
      DONE: begin
        if (!pause) begin
          update_valid = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Row cur takes the contents of the row directly above it.
  always_comb begin
    shifted = cleared_board;
    for (int r = 1; r < BLOCK_HEIGHT; r++) begin
      if (int'(cur) == r) shifted[r*BLOCK_WIDTH +: BLOCK_WIDTH] = cleared_board[(r-1)*BLOCK_WIDTH +: BLOCK_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= '0;
      cleared_board <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            cleared_board <= placed_tetrominos;
            cur           <= row;
          end
        end
        SHIFT: begin
          if (!pause) begin
            cleared_board <= shifted;
            cur           <= cur - Y_POS_IN_BITS'(1);
          end
        end
        CLEAR_TOP: if (!pause) cleared_board[BLOCK_WIDTH-1:0] <= '0;
        DONE:      if (!pause) lines_cleared <= lines_cleared + LINES_BITS'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_row_clear.sv
// Randomized and directed bench for row_clear against a row-queue reference model.
module tb_row_clear;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int YB = 5;
  localparam int LB = 16;
  localparam int BW = W * H;

  logic          clk = 1'b0;
  logic          rst_n, pause, enabled;
  logic [BW-1:0] placed;
  logic [YB-1:0] row;
  logic          busy, uv, busy2, uv2;
  logic [BW-1:0] cb, cb2;
  logic [LB-1:0] lines;
  logic [1:0]    lines2;

  int            checks = 0;
  int            errors = 0;
  int            model_count = 0;
  logic [BW-1:0] board;

  always #5 clk = ~clk;

  row_clear #(.BLOCK_WIDTH(W), .BLOCK_HEIGHT(H), .Y_POS_IN_BITS(YB), .LINES_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .placed_tetrominos(placed), .row(row),
    .enabled(enabled), .busy(busy), .update_valid(uv), .cleared_board(cb), .lines_cleared(lines));

  row_clear #(.BLOCK_WIDTH(W), .BLOCK_HEIGHT(H), .Y_POS_IN_BITS(YB), .LINES_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pause(pause), .placed_tetrominos(placed), .row(row),
    .enabled(enabled), .busy(busy2), .update_valid(uv2), .cleared_board(cb2), .lines_cleared(lines2));

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: drop row r from a list of rows, then push an empty row on top.
  function automatic logic [BW-1:0] remove_row(input logic [BW-1:0] b, input int r);
    logic [W-1:0]  q[$];
    logic [BW-1:0] res;
    for (int i = 0; i < H; i++) q.push_back(b[i*W +: W]);
    q.delete(r);
    q.push_front('0);
    res = '0;
    for (int i = 0; i < H; i++) res[i*W +: W] = q[i];
    return res;
  endfunction

  task automatic do_clear(input int r, input int pl, input string tag);
    int            k;
    int            exp_lat;
    logic [BW-1:0] exp;
    exp     = remove_row(board, r);
    exp_lat = r + 1 + ((r >= 3) ? pl : 0);
    @(negedge clk);
    placed  = board;
    row     = r[YB-1:0];
    enabled = 1'b1;
    @(posedge clk);
    #1 enabled = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    k = 0;
    while (k < 200) begin
      @(posedge clk);
      k++;
      #1;
      if (uv) break;
      if (pl > 0 && r >= 3) begin
        if (k == 3)      pause = 1'b1;
        if (k == 3 + pl) pause = 1'b0;
      end
    end
    pause = 1'b0;
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_board"}, cb, exp);
    model_count++;
    board = exp;
    @(posedge clk);
    #1;
    check({tag, "_strobe_once"}, uv, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_lines"}, lines, model_count[LB-1:0]);
    check({tag, "_lines_wrap"}, lines2, model_count % 4);
  endtask

  initial begin
    int r;
    int strobes;
    rst_n = 1'b0; pause = 1'b0; enabled = 1'b0; placed = '0; row = '0;
    board = '0;
    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_uv", uv, 1'b0);
    check("reset_lines", lines, '0);
    check("reset_board", cb, '0);
    @(negedge clk) rst_n = 1'b1;

    // Bottom row clear
    board = '0;
    board[19*W +: W] = '1;
    board[18*W +: W] = 10'b0000000011;
    do_clear(19, 0, "bottom");

    // Top row clear with other rows populated
    for (int i = 1; i < H; i++) board[i*W +: W] = W'($urandom);
    board[0 +: W] = '1;
    do_clear(0, 0, "top");

    // Pause mid-SHIFT; expected board is pause-independent
    for (int i = 0; i < H; i++) board[i*W +: W] = W'($urandom);
    board[10*W +: W] = '1;
    do_clear(10, 5, "pause");

    // Two full rows handled as two passes
    for (int i = 0; i < 18; i++) board[i*W +: W] = W'($urandom);
    board[18*W +: W] = '1;
    board[19*W +: W] = '1;
    do_clear(19, 0, "b2b_a");
    check("b2b_row19_full", board[19*W +: W], {W{1'b1}});
    do_clear(19, 0, "b2b_b");

    // Out-of-range index is ignored
    @(negedge clk);
    row = 5'd25; enabled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("bad_index_busy", busy, 1'b0);
    end
    enabled = 1'b0;

    // Randomized clears
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < H; i++) board[i*W +: W] = W'($urandom);
      r = $urandom_range(0, H-1);
      board[r*W +: W] = '1;
      do_clear(r, $urandom_range(0, 4), "random");
    end

    // Reset mid-SHIFT abandons the clear
    @(negedge clk);
    placed = board; row = 5'd19; enabled = 1'b1;
    @(posedge clk);
    #1 enabled = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_uv", uv, 1'b0);
    check("midrst_lines", lines, '0);
    check("midrst_board", cb, '0);
    model_count = 0;
    @(negedge clk) rst_n = 1'b1;
    strobes = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (uv) strobes++;
    end
    check("midrst_no_strobe", strobes, 0);
    check("midrst_idle", busy, 1'b0);

    // Normal operation after reset
    board[5*W +: W] = '1;
    do_clear(5, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
